la_rrarb: RTL

Round-robin arbiter that shares one resource among N requesters. Each grant is held until the owner releases it, with an optional hold-time limit that revokes the grant. The block sits in the auxiliary library next to the stdlib gates. It is the standard way to share a bus, a memory port or a gated-clock domain between agents.

---
 rtl/la_rrarb_pkg.sv | 14 +
 rtl/la_rrpick.sv | 41 ++++
 rtl/la_rrarb.sv | 109 ++++++++++
 3 files changed

// File: rtl/la_rrarb_pkg.sv
// Width helpers shared by the round-robin arbiter and its picker.
package la_rrarb_pkg;

    // Index width for N requesters, never narrower than one bit.
    function automatic int gid_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Hold-counter width for a limit of m cycles, never narrower than one bit.
    function automatic int cnt_width(input int m);
        return (m > 0) ? $clog2(m + 1) : 1;
    endfunction

endpackage

// File: rtl/la_rrpick.sv
// Combinational round-robin picker: first unmasked request at or after ptr, wrapping modulo N.
module la_rrpick
    import la_rrarb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            req,
    input  logic [N-1:0]            mask,
    input  logic [gid_width(N)-1:0] ptr,
    output logic [N-1:0]            onehot,
    output logic [gid_width(N)-1:0] idx,
    output logic                    any
);

    localparam int GW = gid_width(N);

    logic [N-1:0] cand;
    int           j;

    assign cand = req & ~mask;

    always_comb begin
        // NOTE: every output of a combinational block gets a default before any branch, so no latch is inferred.
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!any && cand[j]) begin
                any       = 1'b1;
                onehot[j] = 1'b1;
                idx       = GW'(j);
            end
        end
    end

endmodule

// File: rtl/la_rrarb.sv
// Round-robin arbiter: grants are held until release, optionally revoked after MAXHOLD cycles.
module la_rrarb
    import la_rrarb_pkg::*;
#(
    parameter int N       = 4,
    parameter int MAXHOLD = 0,
    parameter     PROP    = "DEFAULT"
) (
    input  logic                    clk,
    input  logic                    nreset,
    input  logic                    en,
    input  logic [N-1:0]            req,
    output logic [N-1:0]            grant,
    output logic                    valid,
    output logic [gid_width(N)-1:0] gid,
    output logic                    expire
);

    localparam int              GW      = gid_width(N);
    localparam int              CW      = cnt_width(MAXHOLD);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAXHOLD);
    localparam logic [GW-1:0]   LAST    = GW'(N - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_n;
    logic [GW-1:0] ptr, ptr_n, gid_n, nxt, pick_ptr, pick_idx;
    logic [CW-1:0] cnt, cnt_n;
    logic [N-1:0]  grant_n, pick_mask, pick_oh;
    logic          pick_any, expire_n, holding, limit_hit;

    // While busy the holder is masked and the scan starts just past it, so one
    // picker serves idle issue, hand-over on release and hand-over on revoke.
    assign nxt       = (gid == LAST) ? '0 : gid + 1'b1;
    assign pick_ptr  = (state == BUSY) ? nxt : ptr;
    assign pick_mask = (state == BUSY) ? grant : '0;
    assign holding   = req[gid];
    assign limit_hit = (MAXHOLD != 0) && (cnt == CNT_MAX);

    la_rrpick #(.N(N)) u_pick (
        .req    (req),
        .mask   (pick_mask),
        .ptr    (pick_ptr),
        .onehot (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    always_comb begin
        state_n  = state;
        ptr_n    = ptr;
        cnt_n    = cnt;
        grant_n  = grant;
        gid_n    = gid;
        expire_n = 1'b0;
        case (state)
            IDLE: begin
                if (en && pick_any) begin
                    grant_n = pick_oh;
                    gid_n   = pick_idx;
                    cnt_n   = CW'(1);
                    state_n = BUSY;
                end
            end
            BUSY: begin
                if (!holding || limit_hit) begin
                    // A release wins over a coincident limit, hence expire only when still requesting.
                    ptr_n    = nxt;
                    expire_n = holding;
                    if (en && pick_any) begin
                        grant_n = pick_oh;
                        gid_n   = pick_idx;
                        cnt_n   = CW'(1);
                    end else begin
                        grant_n = '0;
                        gid_n   = '0;
                        cnt_n   = '0;
                        state_n = IDLE;
                    end
                end else if (MAXHOLD != 0) begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            grant  <= '0;
            gid    <= '0;
            expire <= 1'b0;
        end else begin
            state  <= state_n;
            ptr    <= ptr_n;
            cnt    <= cnt_n;
            grant  <= grant_n;
            gid    <= gid_n;
            expire <= expire_n;
        end
    end

    assign valid = (state == BUSY);

endmodule
